// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer
// Brief    : Serial-in / parallel-out deserializer. Collects WIDTH bits
//            (first bit lands in the MSB) and hands each completed word to a
//            one-entry output buffer with a valid/ready handshake. A completed
//            word that finds the buffer full and not being drained is dropped
//            and raises a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_bit_in,
  input  logic                           i_bit_valid,
  input  logic                           i_clr,
  input  logic                           i_word_ready,
  output logic [WIDTH-1:0]               o_word_out,
  output logic                           o_word_valid,
  output logic [$clog2(WIDTH+1)-1:0]     o_bit_count,
  output logic                           o_overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // Only WIDTH-1 history bits are needed: the last bit of a word comes
  // straight from i_bit_in on the completing edge.
  logic [WIDTH-2:0] r_shift;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_word;
  logic             r_overrun;
  state_t           r_state;

  state_t           w_state_nxt;
  logic             w_complete;
  logic             w_load;
  logic             w_set_ovr;
  logic [WIDTH-1:0] w_candidate;

  assign w_candidate = {r_shift, i_bit_in};
  // clr suppresses completion so a word finishing on a clearing edge is lost.
  assign w_complete  = i_bit_valid && (r_count == c_LAST) && !i_clr;

  // Partial-word shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_bit_valid) begin
      r_shift <= w_candidate[WIDTH-2:0];
      r_count <= w_complete ? '0 : (r_count + c_ONE);
    end
  end

  // Output buffer next-state: drain on ready, load/drop on completion.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_complete) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_complete) begin
          if (i_word_ready) begin
            w_load    = 1'b1;
          end else begin
            w_set_ovr = 1'b1;
          end
        end else if (i_word_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (i_clr) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // Output buffer state, held word and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_word    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_word <= w_candidate;
      end
      if (i_clr) begin
        r_overrun <= 1'b0;
      end else if (w_set_ovr) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_word_out   = r_word;
  assign o_word_valid = (r_state == S_FULL);
  assign o_bit_count  = r_count;
  assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deserializer
// Brief    : Self-checking bench for sipo_deserializer (WIDTH=8): directed
//            scenarios with literal expectations plus randomized traffic
//            compared every cycle against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_bit_in = 1'b0;
  logic         i_bit_valid = 1'b0;
  logic         i_clr = 1'b0;
  logic         i_word_ready = 1'b0;
  logic [W-1:0] o_word_out;
  logic         o_word_valid;
  logic [3:0]   o_bit_count;
  logic         o_overrun;

  int n_chk  = 0;
  int n_fail = 0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_bit_in    (i_bit_in),
    .i_bit_valid (i_bit_valid),
    .i_clr       (i_clr),
    .i_word_ready(i_word_ready),
    .o_word_out  (o_word_out),
    .o_word_valid(o_word_valid),
    .o_bit_count (o_bit_count),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: bits collected so far as an integer, buffer occupancy
  // as a flag. Consumption happens before a new word is offered.
  typedef struct {
    int cnt;
    int acc;
    bit full;
    int out;
    bit ovr;
  } mdl_t;

  mdl_t m = '{cnt: 0, acc: 0, full: 1'b0, out: 0, ovr: 1'b0};

  function automatic mdl_t step(mdl_t cur, bit b, bit v, bit c, bit rdy);
    mdl_t nx = cur;
    bit   done = 1'b0;
    int   cand = 0;
    if (c) begin
      nx.cnt  = 0;
      nx.acc  = 0;
      nx.full = 1'b0;
      nx.ovr  = 1'b0;
      return nx;
    end
    if (v) begin
      cand   = ((cur.acc * 2) + int'(b)) % (1 << W);
      nx.acc = cand;
      if (cur.cnt + 1 == W) begin
        done   = 1'b1;
        nx.cnt = 0;
      end else begin
        nx.cnt = cur.cnt + 1;
      end
    end
    if (cur.full && rdy) nx.full = 1'b0;
    if (done) begin
      if (!nx.full) begin
        nx.full = 1'b1;
        nx.out  = cand;
      end else begin
        nx.ovr = 1'b1;
      end
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{cnt: 0, acc: 0, full: 1'b0, out: 0, ovr: 1'b0};
    else        m <= step(m, i_bit_in, i_bit_valid, i_clr, i_word_ready);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("mdl_word_out",   int'(o_word_out),   m.out);
    chk("mdl_word_valid", int'(o_word_valid), int'(m.full));
    chk("mdl_bit_count",  int'(o_bit_count),  m.cnt);
    chk("mdl_overrun",    int'(o_overrun),    int'(m.ovr));
  end

  // Apply inputs for one edge; returns 1 time unit after that edge.
  task automatic cyc(input bit b, input bit v, input bit c, input bit rdy);
    i_bit_in     = b;
    i_bit_valid  = v;
    i_clr        = c;
    i_word_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] wd, input bit rdy, input bit rdy_last);
    for (int k = 7; k >= 0; k--) begin
      cyc(wd[k], 1'b1, 1'b0, (k == 0) ? rdy_last : rdy);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] pat;

  initial begin
    // Reset held from time zero.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_word_out", int'(o_word_out), 0);
    chk("rst_valid",    int'(o_word_valid), 0);
    chk("rst_count",    int'(o_bit_count), 0);
    chk("rst_overrun",  int'(o_overrun), 0);
    rst_n = 1'b1;
    idle();

    // Basic word with ready high: B2, valid for one cycle, counts 1..7,0.
    pat = 8'hB2;
    for (int k = 7; k >= 0; k--) begin
      cyc(pat[k], 1'b1, 1'b0, 1'b1);
      chk("seq_count", int'(o_bit_count), (8 - k) % 8);
    end
    chk("b2_word",  int'(o_word_out), 8'hB2);
    chk("b2_valid", int'(o_word_valid), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2_valid_drop", int'(o_word_valid), 0);
    chk("b2_word_hold",  int'(o_word_out), 8'hB2);

    // Same stream with bit_valid gaps; count holds on gap cycles.
    pat = 8'h4D;
    for (int k = 7; k >= 0; k--) begin
      cyc(pat[k], 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (k != 0) chk("gap_count_hold", int'(o_bit_count), 8 - k);
    end
    chk("gap_word", int'(o_word_out), 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: B2 then 5A with ready low.
    send_word(8'hB2, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    chk("ovr_word",    int'(o_word_out), 8'hB2);
    chk("ovr_valid",   int'(o_word_valid), 1);
    chk("ovr_flag",    int'(o_overrun), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_valid",   int'(o_word_valid), 0);
    chk("clr_overrun", int'(o_overrun), 0);
    chk("clr_count",   int'(o_bit_count), 0);

    // Consume and reload on the same edge.
    send_word(8'hB2, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b1);
    chk("swap_word",    int'(o_word_out), 8'h5A);
    chk("swap_valid",   int'(o_word_valid), 1);
    chk("swap_overrun", int'(o_overrun), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-word.
    send_word(8'hB2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_word",    int'(o_word_out), 0);
    chk("arst_valid",   int'(o_word_valid), 0);
    chk("arst_count",   int'(o_bit_count), 0);
    chk("arst_overrun", int'(o_overrun), 0);
    i_bit_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    chk("arst_no_pulse", int'(o_word_valid), 0);
    send_word(8'hFF, 1'b0, 1'b0);
    chk("ff_word",  int'(o_word_out), 8'hFF);
    chk("ff_valid", int'(o_word_valid), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // clr on the 8th bit edge.
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr8_valid", int'(o_word_valid), 0);
    chk("clr8_count", int'(o_bit_count), 0);
    chk("clr8_word",  int'(o_word_out), 8'hFF);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 2) == 0));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
